dat_read_seq: RTL

//  Sequences the 4-bit DAT read datapath across multi-block transfers.

---
 rtl/dat_read_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dat_read_seq.sv
// DAT read sequencer: walks a multi-block read, one rd_start_o per block, gated on buffer room,
// with a per-block data timeout, sticky error aggregation and a registered word path to the buffer.
module dat_read_seq #(
  parameter int MaxBlockBitSize = 12,
  parameter int TimeoutWidth    = 20
) (
  input  logic                       sd_clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [15:0]                block_count_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [TimeoutWidth-1:0]    timeout_i,
  input  logic                       buf_ready_i,
  output logic                       rd_start_o,
  output logic [MaxBlockBitSize-1:0] rd_block_size_o,
  output logic                       rd_abort_o,
  input  logic                       rd_data_valid_i,
  input  logic [31:0]                rd_data_i,
  input  logic                       rd_done_i,
  input  logic                       rd_crc_err_i,
  input  logic                       rd_end_bit_err_i,
  output logic                       data_valid_o,
  output logic [31:0]                data_o,
  output logic                       clk_stop_o,
  output logic                       busy_o,
  output logic                       block_done_o,
  output logic                       xfer_done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       timeout_err_o,
  output logic [15:0]                blocks_left_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUF,
    S_ARM,
    S_RECV,
    S_DONE
  } state_e;

  state_e                     r_state;
  logic [TimeoutWidth-1:0]    r_tmo;
  logic [TimeoutWidth-1:0]    r_tmo_cnt;
  logic                       r_stop_pend;
  logic [MaxBlockBitSize-1:0] r_blk_size;
  logic [15:0]                r_blocks_left;
  logic                       r_rd_start, r_abort, r_data_valid, r_clk_stop, r_busy;
  logic                       r_block_done, r_xfer_done, r_crc_err, r_eb_err, r_to_err;
  logic [31:0]                r_data;

  logic                    w_stop;
  logic                    w_tmo_hit;
  logic                    w_blk_err;
  logic [15:0]             w_left_dec;
  logic [TimeoutWidth-1:0] w_tmo_eff;

  // A stop arriving in the same cycle as a boundary decision counts as pending.
  assign w_stop     = r_stop_pend | stop_i;
  assign w_tmo_hit  = (r_tmo_cnt == (r_tmo - TimeoutWidth'(1)));
  assign w_blk_err  = rd_crc_err_i | rd_end_bit_err_i;
  assign w_left_dec = (r_blocks_left != 16'd0) ? (r_blocks_left - 16'd1) : 16'd0;
  assign w_tmo_eff  = (timeout_i == '0) ? '1 : timeout_i;

  always_ff @(posedge sd_clk_i) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_tmo         <= '0;
      r_tmo_cnt     <= '0;
      r_stop_pend   <= 1'b0;
      r_blk_size    <= '0;
      r_blocks_left <= '0;
      r_rd_start    <= 1'b0;
      r_abort       <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data        <= '0;
      r_clk_stop    <= 1'b0;
      r_busy        <= 1'b0;
      r_block_done  <= 1'b0;
      r_xfer_done   <= 1'b0;
      r_crc_err     <= 1'b0;
      r_eb_err      <= 1'b0;
      r_to_err      <= 1'b0;
    end else begin
      r_rd_start   <= 1'b0;
      r_abort      <= 1'b0;
      r_block_done <= 1'b0;
      r_xfer_done  <= 1'b0;
      r_clk_stop   <= 1'b0;

      // Words are only meaningful while a block is being received.
      r_data_valid <= (r_state == S_RECV) && rd_data_valid_i;
      if ((r_state == S_RECV) && rd_data_valid_i) r_data <= rd_data_i;

      if ((r_state != S_IDLE) && stop_i) r_stop_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_stop_pend <= 1'b0;
          if (start_i) begin
            r_blk_size    <= block_size_i;
            r_tmo         <= w_tmo_eff;
            r_blocks_left <= block_count_i;
            r_crc_err     <= 1'b0;
            r_eb_err      <= 1'b0;
            r_to_err      <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= (block_count_i == 16'd0) ? S_DONE : S_WAIT_BUF;
          end
        end
        S_WAIT_BUF: begin
          if (w_stop)           r_state <= S_DONE;
          else if (buf_ready_i) r_state <= S_ARM;
          else                  r_clk_stop <= 1'b1;
        end
        S_ARM: begin
          r_tmo_cnt  <= '0;
          r_rd_start <= 1'b1;
          r_state    <= S_RECV;
        end
        S_RECV: begin
          if (rd_done_i) begin
            if (w_blk_err) begin
              r_crc_err <= r_crc_err | rd_crc_err_i;
              r_eb_err  <= r_eb_err  | rd_end_bit_err_i;
              r_state   <= S_DONE;
            end else begin
              r_block_done  <= 1'b1;
              r_blocks_left <= w_left_dec;
              r_state       <= ((w_left_dec == 16'd0) || w_stop) ? S_DONE : S_WAIT_BUF;
            end
          end else if (w_tmo_hit) begin
            r_to_err <= 1'b1;
            r_abort  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TimeoutWidth'(1);
          end
        end
        S_DONE: begin
          r_xfer_done <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_start_o      = r_rd_start;
  assign rd_block_size_o = r_blk_size;
  assign rd_abort_o      = r_abort;
  assign data_valid_o    = r_data_valid;
  assign data_o          = r_data;
  assign clk_stop_o      = r_clk_stop;
  assign busy_o          = r_busy;
  assign block_done_o    = r_block_done;
  assign xfer_done_o     = r_xfer_done;
  assign crc_err_o       = r_crc_err;
  assign end_bit_err_o   = r_eb_err;
  assign timeout_err_o   = r_to_err;
  assign blocks_left_o   = r_blocks_left;

endmodule
